// File: rtl/maxnet_host_if.sv
// Host-side sequencer for the Maxnet WTA datapath: collects epsilon + four
// activations, pulses start, waits (with timeout) for finish, returns result.
module maxnet_host_if #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] epsilon,
  output logic [WIDTH-1:0] a1_init,
  output logic [WIDTH-1:0] a2_init,
  output logic [WIDTH-1:0] a3_init,
  output logic [WIDTH-1:0] a4_init,
  output logic             net_start,
  input  logic             net_finish,
  input  logic [WIDTH-1:0] net_out,
  output logic [WIDTH-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_timeout,
  output logic             busy
);

  typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_RESULT} state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t                  state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [WIDTH-1:0]        eps_q, eps_d;
  logic [3:0][WIDTH-1:0]   act_q, act_d;
  logic [WIDTH-1:0]        res_data_q, res_data_d;
  logic                    res_to_q, res_to_d;
  logic [1:0]              slot;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    eps_d      = eps_q;
    act_d      = act_q;
    res_data_d = res_data_q;
    res_to_d   = res_to_q;
    // word index 1..4 maps onto activation slots 0..3
    slot       = idx_q[1:0] - 2'd1;
    case (state_q)
      S_LOAD: if (in_valid) begin
        if (idx_q == 3'd0) eps_d = in_data;
        else               act_d[slot] = in_data;
        if (idx_q == 3'd4) begin
          idx_d   = 3'd0;
          state_d = S_START;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_START: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // finish takes priority over an expiring timeout in the same cycle
        if (net_finish) begin
          res_data_d = net_out;
          res_to_d   = 1'b0;
          state_d    = S_RESULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TO_LIM) begin
            res_data_d = '0;
            res_to_d   = 1'b1;
            state_d    = S_RESULT;
          end
        end
      end
      S_RESULT: if (res_ready) state_d = S_LOAD;
      default:  state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_LOAD;
      idx_q      <= 3'd0;
      cnt_q      <= 8'd0;
      eps_q      <= '0;
      act_q      <= '0;
      res_data_q <= '0;
      res_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      eps_q      <= eps_d;
      act_q      <= act_d;
      res_data_q <= res_data_d;
      res_to_q   <= res_to_d;
    end
  end

  assign in_ready    = (state_q == S_LOAD);
  assign net_start   = (state_q == S_START);
  assign res_valid   = (state_q == S_RESULT);
  assign busy        = (state_q == S_START) || (state_q == S_WAIT);
  assign epsilon     = eps_q;
  assign a1_init     = act_q[0];
  assign a2_init     = act_q[1];
  assign a3_init     = act_q[2];
  assign a4_init     = act_q[3];
  assign res_data    = res_data_q;
  assign res_timeout = res_to_q;

endmodule

// File: tb/tb_maxnet_host_if.sv
// Directed bench: u0 (TIMEOUT=32) covers normal/bubble/stall/reset runs,
// u1 (TIMEOUT=8) covers timeout and finish/timeout collision.
module tb_maxnet_host_if;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst0, rst1;
  logic [W-1:0] in_data;
  logic         in_valid, net_finish, res_ready;
  logic [W-1:0] net_out;

  logic         rdy0, st0, rv0, to0, bz0;
  logic [W-1:0] eps0, a10, a20, a30, a40, rd0;
  logic         rdy1, st1, rv1, to1, bz1;
  logic [W-1:0] eps1, a11, a21, a31, a41, rd1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  maxnet_host_if #(.WIDTH(W), .TIMEOUT(32)) u0 (
    .clk(clk), .rst(rst0), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
    .epsilon(eps0), .a1_init(a10), .a2_init(a20), .a3_init(a30), .a4_init(a40),
    .net_start(st0), .net_finish(net_finish), .net_out(net_out),
    .res_data(rd0), .res_valid(rv0), .res_ready(res_ready), .res_timeout(to0), .busy(bz0));

  maxnet_host_if #(.WIDTH(W), .TIMEOUT(8)) u1 (
    .clk(clk), .rst(rst1), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
    .epsilon(eps1), .a1_init(a11), .a2_init(a21), .a3_init(a31), .a4_init(a41),
    .net_start(st1), .net_finish(net_finish), .net_out(net_out),
    .res_data(rd1), .res_valid(rv1), .res_ready(res_ready), .res_timeout(to1), .busy(bz1));

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives five words; on return we sit in the cycle after the 5th accept (START).
  task automatic load(input logic [W-1:0] w0, w1, w2, w3, w4, input bit bubble);
    logic [W-1:0] w [5];
    w = '{w0, w1, w2, w3, w4};
    for (int i = 0; i < 5; i++) begin
      in_data = w[i]; in_valid = 1'b1;
      @(negedge clk);
      if (bubble && i < 4) begin
        in_valid = 1'b0; in_data = 32'hDEAD_BEEF;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0;
    in_data = '0; in_valid = 1'b0; net_finish = 1'b0; net_out = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);

    // reset state
    chk("rst_in_ready", rdy0, 1);  chk("rst_net_start", st0, 0);
    chk("rst_res_valid", rv0, 0);  chk("rst_res_timeout", to0, 0);
    chk("rst_busy", bz0, 0);       chk("rst_res_data", rd0, 0);
    chk("rst_epsilon", eps0, 0);   chk("rst_a4", a40, 0);

    // normal run, finish after 20 WAIT cycles
    load(32'h10, 5, 9, 3, 7, 0);
    chk("norm_start", st0, 1); chk("norm_busy_start", bz0, 1); chk("norm_rdy_start", rdy0, 0);
    chk("norm_eps", eps0, 32'h10); chk("norm_a1", a10, 5); chk("norm_a2", a20, 9);
    chk("norm_a3", a30, 3); chk("norm_a4", a40, 7);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin chk("norm_start_pulse", st0, 0); chk("norm_busy_wait", bz0, 1); end
      if (k == 20) begin net_finish = 1'b1; net_out = 9; end
    end
    @(negedge clk);
    net_finish = 1'b0; net_out = 32'h5555;
    chk("norm_res_valid", rv0, 1); chk("norm_res_data", rd0, 9);
    chk("norm_res_to", to0, 0);    chk("norm_busy_res", bz0, 0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("norm_post_rv", rv0, 0); chk("norm_post_rdy", rdy0, 1);

    // bubbles, extra words during WAIT, stalled result
    load(32'h111, 32'h222, 32'h333, 32'h444, 32'h555, 1);
    chk("bub_eps", eps0, 32'h111); chk("bub_a1", a10, 32'h222); chk("bub_a2", a20, 32'h333);
    chk("bub_a3", a30, 32'h444);   chk("bub_a4", a40, 32'h555); chk("bub_start", st0, 1);
    in_valid = 1'b1; in_data = 32'hBAD0_0BAD;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("bub_rdy_wait", rdy0, 0);
      if (k == 3) begin net_finish = 1'b1; net_out = 32'hCAFE_F00D; end
    end
    @(negedge clk);
    net_finish = 1'b0; net_out = 32'h0;
    for (int k = 0; k < 10; k++) begin
      chk("stall_rv", rv0, 1); chk("stall_rd", rd0, 32'hCAFE_F00D);
      chk("stall_rdy", rdy0, 0);
      @(negedge clk);
    end
    chk("bub_eps_held", eps0, 32'h111); chk("bub_a4_held", a40, 32'h555);
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("stall_post_rv", rv0, 0); chk("stall_post_rdy", rdy0, 1);
    chk("stall_post_rd", rd0, 32'hCAFE_F00D);

    // reset after 3 accepted words
    in_valid = 1'b1;
    in_data = 32'hA0; @(negedge clk);
    in_data = 32'hA1; @(negedge clk);
    in_data = 32'hA2; @(negedge clk);
    in_valid = 1'b0;
    chk("part_eps", eps0, 32'hA0);
    #2 rst0 = 1'b0;
    #1;
    chk("rstl_eps", eps0, 0); chk("rstl_a1", a10, 0); chk("rstl_a2", a20, 0);
    chk("rstl_rd", rd0, 0);   chk("rstl_rdy", rdy0, 1);
    @(negedge clk);
    rst0 = 1'b1;
    load(32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 0);
    chk("rld_eps", eps0, 32'hB0); chk("rld_a1", a10, 32'hB1); chk("rld_a4", a40, 32'hB4);
    chk("rld_start", st0, 1);

    // reset during WAIT
    repeat (3) @(negedge clk);
    chk("rstw_busy_pre", bz0, 1);
    #2 rst0 = 1'b0;
    #1;
    chk("rstw_busy", bz0, 0); chk("rstw_start", st0, 0); chk("rstw_rv", rv0, 0);
    chk("rstw_rdy", rdy0, 1); chk("rstw_eps", eps0, 0); chk("rstw_a3", a30, 0);
    @(negedge clk);
    rst0 = 1'b1;
    load(32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 0);
    @(negedge clk);
    net_finish = 1'b1; net_out = 32'h1234;
    @(negedge clk);
    net_finish = 1'b0;
    chk("rstw_rerun_rv", rv0, 1); chk("rstw_rerun_rd", rd0, 32'h1234);
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;

    // TIMEOUT=8 instance
    rst0 = 1'b0; rst1 = 1'b1;
    @(negedge clk);

    // collision: finish in WAIT cycle 8
    load(1, 2, 3, 4, 5, 0);
    chk("col_start", st1, 1);
    repeat (8) @(negedge clk);
    chk("col_rv_pre", rv1, 0);
    net_finish = 1'b1; net_out = 32'hA5;
    @(negedge clk);
    net_finish = 1'b0;
    chk("col_rv", rv1, 1); chk("col_rd", rd1, 32'hA5); chk("col_to", to1, 0);
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;

    // timeout: no finish, result 9 cycles after start
    load(6, 7, 8, 9, 10, 0);
    chk("to_start", st1, 1);
    repeat (8) @(negedge clk);
    chk("to_rv_pre", rv1, 0); chk("to_busy_pre", bz1, 1);
    @(negedge clk);
    chk("to_rv", rv1, 1); chk("to_rd", rd1, 0); chk("to_flag", to1, 1);
    net_finish = 1'b1; net_out = 32'h77;
    repeat (2) @(negedge clk);
    chk("to_late_rd", rd1, 0); chk("to_late_flag", to1, 1); chk("to_late_rv", rv1, 1);
    net_finish = 1'b0;
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    chk("to_post_rdy", rdy1, 1); chk("to_post_rv", rv1, 0);
    chk("to_eps_held", eps1, 6); chk("to_a4_held", a41, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/maxnet_host_if.md
# maxnet_host_if

Host-side sequencer for the Maxnet winner-take-all datapath. It accepts a five-word load stream (epsilon, then a1..a4) over a valid/ready handshake and presents those values as stable initial inputs to the network. It then pulses the network start, waits for the network's finish indication, and returns the winning value to the host over a second valid/ready handshake. A cycle-count timeout guards against non-converging inputs.

## Interface

Parameters:
- WIDTH, 32, data word width (activations, epsilon, result)
- TIMEOUT, 255, maximum WAIT cycles before abort; legal range 1..255

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-low reset
- in_data  input  WIDTH  load word
- in_valid  input  1  load word valid
- in_ready  output  1  block can accept a load word
- epsilon  output  WIDTH  held epsilon to network
- a1_init, a2_init, a3_init, a4_init  output  WIDTH each  held initial activations to network
- net_start  output  1  one-cycle start pulse to network
- net_finish  input  1  network result valid
- net_out  input  WIDTH  network winning value
- res_data  output  WIDTH  result to host
- res_valid  output  1  result valid
- res_ready  input  1  host accepts result
- res_timeout  output  1  qualifies res_data: 1 = aborted by timeout
- busy  output  1  high in START and WAIT

## Operation

- FSM states: LOAD, START, WAIT, RESULT. Reset state is LOAD with the 3-bit word index at 0.
- LOAD: in_ready=1. A word is accepted when in_valid && in_ready at a clock edge.
  - Index 0 writes epsilon; indices 1..4 write a1_init..a4_init.
  - The index increments per accept.
  - The accept at index 4 moves to START and clears the index.
  - in_valid low holds state.
- START: net_start=1 for exactly this cycle. The WAIT counter (8 bits) is cleared. Next state is WAIT.
- WAIT: net_finish is sampled every cycle.
  - finish=1: capture net_out into res_data, clear res_timeout, go to RESULT.
  - Otherwise the counter increments. When the counter reaches TIMEOUT, set res_data=0 and res_timeout=1, then go to RESULT.
  - If finish and the timeout condition occur in the same cycle, finish wins.
- RESULT: res_valid=1. res_data and res_timeout are held stable until res_valid && res_ready. On that handshake, go to LOAD.
- Held outputs:
  - epsilon and a*_init change only on their own accept. They remain stable through START, WAIT and RESULT, and persist into the next load until overwritten.
- Ignored inputs:
  - net_finish outside WAIT is ignored.
  - in_valid outside LOAD is ignored; in_ready=0 there.
- Arithmetic: no arithmetic on data. Words pass through bit-exact; signedness is irrelevant.
- Reset (asynchronous, any state, including mid-load or mid-WAIT):
  - All registers clear, including epsilon, a*_init, res_data and the counters.
  - State returns to LOAD at index 0.
  - A partial load is discarded.

## Timing

- Reset values: in_ready=1, net_start=0, res_valid=0, res_timeout=0, busy=0, res_data=0, epsilon=0, a1..a4_init=0.
- The 5th accept edge is followed by net_start=1 in the next cycle, then busy=1 for the START and WAIT cycles.
- Minimum load: 5 consecutive cycles with in_valid=1.
- net_finish sampled high at WAIT edge k: res_valid=1 from the following cycle (1-cycle latency).
- Timeout:
  - The first WAIT cycle is k=1.
  - With no finish, res_valid rises in the cycle after WAIT cycle k=TIMEOUT.
  - Therefore start-pulse to res_valid = TIMEOUT+1 cycles.
- Result handshake edge: res_valid=0 and in_ready=1 in the next cycle, so the next load can begin immediately.
- With res_ready tied high, RESULT lasts exactly one cycle.
- in_ready, net_start, res_valid and busy are decoded from registered state (no input-to-output combinational path).

## Test plan

- Normal run:
  - Stimulus: load 0x10, 5, 9, 3, 7 on back-to-back cycles. A network model raises net_finish with net_out=9 after 20 WAIT cycles.
  - Required: epsilon=0x10, a1..a4=5,9,3,7; one net_start pulse in the cycle after the 5th accept; res_valid one cycle after finish with res_data=9 and res_timeout=0.
- Bubbles and backpressure:
  - Stimulus: in_valid toggles 1,0,1,0…; extra words are driven during WAIT.
  - Required: exactly 5 words accepted in order; in_ready=0 during START/WAIT/RESULT; extra words do not alter the held outputs.
- Timeout:
  - Stimulus: TIMEOUT=8, net_finish never asserted.
  - Required: res_valid rises 9 cycles after net_start, with res_data=0 and res_timeout=1. Then:
    - a late net_finish has no effect;
    - after the handshake, in_ready=1.
- Result stall:
  - Stimulus: res_ready held 0 for 10 cycles after res_valid rises, then pulsed.
  - Required: res_data and res_valid stable throughout; state returns to LOAD on the handshake edge.
- Finish/timeout collision:
  - Stimulus: TIMEOUT=8, net_finish=1 with net_out=0xA5 in WAIT cycle 8.
  - Required: res_data=0xA5, res_timeout=0.
- Reset mid-operation:
  - Stimulus: assert rst low asynchronously after 3 accepted words, and again during WAIT.
  - Required: all outputs immediately at reset values. A subsequent full load runs normally from index 0.
